fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Front-end fetch stage: generates the sequential PC and issues in-order word requests to instruction memory.
// - Pushes each returned {pc, instr} pair into the downstream instruction queue (circular_buffer, T = logic [63:0]).
// - Uses credit-based flow control so the queue is never written while full.
// - On a redirect (branch mispredict / exception) it squashes in-flight responses and restarts at the new PC.
// PARAMETERS
// - RESET_PC         32'h0000_0000  PC fetched first after reset
// - BUF_DEPTH        8              depth of the downstream instruction queue; must match its DEPTH
// - MAX_OUTSTANDING  2              max imem requests in flight; power of 2, >= 1
// PORTS
// - clk              in   1   clock, rising edge
// - reset            in   1   asynchronous, active-low reset
// - imem_req_valid   out  1   request valid
// - imem_req_ready   in   1   memory accepts request
// - imem_req_addr    out  32  word-aligned fetch address (= pc)
// - imem_rsp_valid   in   1   response valid; responses return in request order, >= 1 cycle after accept
// - imem_rsp_data    in   32  instruction word
// - buf_write_en     out  1   queue push
// - buf_write_data   out  64  {pc[31:0], instr[31:0]}
// - buf_read_en      in   1   consumer pop of the queue (observed for credit tracking)
// - buf_empty        in   1   queue empty flag
// - redirect_valid   in   1   squash + restart; the same signal flushes the queue this cycle
// - redirect_pc      in   32  new PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
// - Reset values: pc = RESET_PC, state = S_RUN, occ = 0, outstanding = 0, drop_cnt = 0, PC FIFO empty; all outputs 0.
// - Counters:
//   - occ = queue occupancy: +1 on buf_write_en, -1 on (buf_read_en && !buf_empty), cleared on redirect_valid.
//   - outstanding: +1 on request accept, -1 on imem_rsp_valid.
// - Request issue: imem_req_valid = (state == S_RUN) && !redirect_valid && (outstanding < MAX_OUTSTANDING) && (occ + outstanding < BUF_DEPTH).
//   - Accept (valid && ready): push pc into the internal PC FIFO (depth MAX_OUTSTANDING); pc <= pc + 4.
//   - pc wraps modulo 2^32.
//   - Hold addr stable while valid && !ready.
// - Response path (combinational, zero latency):
//   - If drop_cnt == 0 and !redirect_valid: buf_write_en = imem_rsp_valid; data = {PC FIFO head, imem_rsp_data}; pop the PC FIFO.
//   - Otherwise the response is discarded: pop the PC FIFO; drop_cnt -= 1 (when drop_cnt > 0).
// - Full never reached by construction; the credit check guarantees occ < BUF_DEPTH on every push.
// - FSM:
//   - S_RUN -> S_DRAIN on redirect_valid when outstanding_next > 0 (outstanding_next = outstanding after this cycle's response); drop_cnt <= outstanding_next.
//   - S_RUN stays S_RUN on redirect_valid when outstanding_next == 0.
//   - S_DRAIN: no requests; -> S_RUN in the cycle after drop_cnt reaches 0.
//   - Redirect in S_DRAIN: reloads pc and recomputes drop_cnt with the same rule.
//   - Any redirect: pc <= {redirect_pc[31:2], 2'b00}.
// - Simultaneous events:
//   - redirect + response in the same cycle -> response dropped.
//   - redirect + pop in the same cycle -> occ = 0 (flush wins).
//   - push + pop in the same cycle -> occ unchanged.
// - Reset mid-operation: all state clears immediately (async). In-flight memory responses are the memory's responsibility; the memory is reset with the same signal.
// CONFIGURATION
// - FETCH_PERF_EN defined:
//   - Adds output perf_stall_cycles [31:0], reset 0.
//   - Increments each cycle state == S_RUN && !imem_req_valid && !redirect_valid (credit/outstanding stall); saturates at 32'hFFFF_FFFF.
// - FETCH_PERF_EN undefined: port and counter absent; no other behaviour change.
// TESTING
// - Reset release, ready = 1, 1-cycle memory -> addrs 0x0, 0x4, 0x8...; pushes {0x0, I0}, {0x4, I1} in order.
// - Consumer never pops, BUF_DEPTH = 8 -> exactly 8 pushes, then imem_req_valid held 0; buf_write_en never asserted while occ == 8.
// - Redirect to 0x1003 with 2 in flight -> next addr 0x1000; the 2 stale responses are not pushed; state returns to S_RUN after both arrive.
// - Redirect in the same cycle as a response -> that response dropped; occ = 0 next cycle.
// - imem_req_ready low for 5 cycles -> imem_req_addr stable; pc advances only on accept.
// - FETCH_PERF_EN, queue full for 10 cycles -> perf_stall_cycles == 10.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC, in-order imem requests, credit-checked pushes into the instruction queue.
// Optional stall counter port perf_stall_cycles is built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BUF_DEPTH       = 8,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        buf_write_en,
  output logic [63:0] buf_write_data,
  input  logic        buf_read_en,
  input  logic        buf_empty,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] DEPTH_U = 32'(BUF_DEPTH);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_DRAIN = 1'b1} state_e;

  state_e             state_q;
  logic [31:0]        pc_q, pc_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic [OUT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]        pc_fifo_q [MAX_OUTSTANDING];
  logic [31:0]        credit_sum_s;
  logic               req_valid_s, accept_s, push_s, pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1'b1);
    end
  endfunction

  // Request credit check and response acceptance; outputs stay low while reset is held.
  always_comb begin
    credit_sum_s = 32'(occ_q) + 32'(outstanding_q);
    req_valid_s  = reset && (state_q == S_RUN) && !redirect_valid &&
                   (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && (credit_sum_s < DEPTH_U);
    accept_s     = req_valid_s && imem_req_ready;
    push_s       = reset && imem_rsp_valid && (drop_cnt_q == {OUT_W{1'b0}}) && !redirect_valid;
    pop_s        = buf_read_en && !buf_empty;
  end

  // Next-state values for counters, PC and PC-FIFO pointers.
  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(accept_s) - OUT_W'(imem_rsp_valid);
    wr_ptr_d      = accept_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d      = imem_rsp_valid ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (redirect_valid) begin
      // Responses still owed after this cycle belong to the squashed path.
      drop_cnt_d = outstanding_d;
      occ_d      = {OCC_W{1'b0}};
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (imem_rsp_valid && (drop_cnt_q != {OUT_W{1'b0}})) begin
        drop_cnt_d = drop_cnt_q - OUT_W'(1'b1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      occ_d = occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
      pc_d  = accept_s ? (pc_q + 32'd4) : pc_q;
    end
  end

  // Counter, PC and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      occ_q         <= {OCC_W{1'b0}};
      outstanding_q <= {OUT_W{1'b0}};
      drop_cnt_q    <= {OUT_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
    end else begin
      pc_q          <= pc_d;
      occ_q         <= occ_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // PC FIFO storage: one entry per request in flight, consumed in response order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        pc_fifo_q[i] <= 32'h0;
      end
    end else if (accept_s) begin
      pc_fifo_q[wr_ptr_q] <= pc_q;
    end
  end

  // Run/drain FSM; a redirect always re-evaluates the drain need from the post-cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
    end else if (redirect_valid) begin
      state_q <= (outstanding_d != {OUT_W{1'b0}}) ? S_DRAIN : S_RUN;
    end else begin
      case (state_q)
        S_RUN:   state_q <= S_RUN;
        S_DRAIN: state_q <= (drop_cnt_q == {OUT_W{1'b0}}) ? S_RUN : S_DRAIN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_q;
  assign buf_write_en   = push_s;
  assign buf_write_data = push_s ? {pc_fifo_q[rd_ptr_q], imem_rsp_data} : 64'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q;

  // Stall counter: running but unable to issue for credit/outstanding reasons; saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 32'h0;
    end else if ((state_q == S_RUN) && !req_valid_s && !redirect_valid && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder, consumer, and a queue-based reference of
// in-flight fetches (stale-tagged after redirects) checked every cycle.
module tb_fetch_unit;
  localparam int DEPTH = 8;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        buf_write_en;
  logic [63:0] buf_write_data;
  logic        buf_read_en, buf_empty;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .buf_write_en(buf_write_en), .buf_write_data(buf_write_data),
    .buf_read_en(buf_read_en), .buf_empty(buf_empty),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct {logic [31:0] addr; int due;} mreq_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // stimulus controls
  bit tb_rst, tb_ready, tb_read, tb_redir;
  logic [31:0] tb_rpc;
  int mem_lat;

  // memory model and observation log
  mreq_t mq[$];
  logic [63:0] push_log[$];
  bit last_req, last_acc, last_push, last_rsp;
  logic [31:0] last_addr;

  // reference model
  logic [31:0] m_pc;
  logic [31:0] m_infl[$];
  int m_stale, m_prev_stale, m_occ, m_perf;
  bit m_prev_redir;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit rsp, blocked, exp_req, exp_we, acc;
    logic [31:0] rdata, hpc;
    int st0;
    @(negedge clk);
    reset          = tb_rst;
    imem_req_ready = tb_ready;
    buf_read_en    = tb_read;
    redirect_valid = tb_redir;
    redirect_pc    = tb_rpc;
    buf_empty      = (m_occ == 0);
    rsp   = tb_rst && (mq.size() > 0) && (mq[0].due <= cyc);
    rdata = rsp ? instr_of(mq[0].addr) : 32'h0;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    last_req  = imem_req_valid;
    last_addr = imem_req_addr;
    last_acc  = imem_req_valid && tb_ready;
    last_push = buf_write_en;
    last_rsp  = rsp;
    if (!tb_rst) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
      chk("rst_write_en", 64'(buf_write_en), 64'h0);
      chk("rst_addr", 64'(imem_req_addr), 64'h0);
      chk("rst_write_data", buf_write_data, 64'h0);
`ifdef FETCH_PERF_EN
      chk("rst_perf", 64'(perf_stall_cycles), 64'h0);
`endif
      m_pc = 32'h0; m_infl.delete(); m_stale = 0; m_prev_stale = 0; m_prev_redir = 1'b0;
      m_occ = 0; m_perf = 0;
      mq.delete();
    end else begin
      st0     = m_stale;
      blocked = (m_stale > 0) || ((m_prev_stale > 0) && !m_prev_redir);
      exp_req = !tb_redir && !blocked && (m_infl.size() < MAXO) && ((m_occ + m_infl.size()) < DEPTH);
      exp_we  = 1'b0;
      hpc     = 32'h0;
      if (rsp) begin
        checks++;
        if (m_infl.size() == 0) begin
          errors++;
          $display("FAIL rsp_tracking: response with no modelled request in flight (cycle %0d)", cyc);
        end else begin
          hpc = m_infl.pop_front();
          exp_we = (m_stale == 0) && !tb_redir;
          if (m_stale > 0) m_stale--;
        end
      end
      chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
      chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
      chk("write_en", 64'(buf_write_en), 64'(exp_we));
      if (exp_we) chk("write_data", buf_write_data, {hpc, rdata});
      chk("write_at_full", 64'(buf_write_en && (m_occ >= DEPTH)), 64'h0);
      if (!blocked && !exp_req && !tb_redir) m_perf++;
`ifdef FETCH_PERF_EN
      chk("perf", 64'(perf_stall_cycles), 64'(m_perf));
`endif
      if (buf_write_en) push_log.push_back(buf_write_data);
      if (rsp) void'(mq.pop_front());
      if (imem_req_valid && tb_ready) mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      acc = exp_req && tb_ready;
      if (acc) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (tb_redir) begin
        m_stale = m_infl.size();
        m_pc    = tb_rpc & 32'hFFFF_FFFC;
        m_occ   = 0;
      end else begin
        m_occ = m_occ + (exp_we ? 1 : 0) - ((tb_read && (m_occ > 0)) ? 1 : 0);
      end
      m_prev_stale = st0;
      m_prev_redir = tb_redir;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bit found;
    reset = 1'b0; imem_req_ready = 1'b0; buf_read_en = 1'b0; buf_empty = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    tb_rst = 1'b0; tb_ready = 1'b0; tb_read = 1'b0; tb_redir = 1'b0; tb_rpc = 32'h0; mem_lat = 1;
    repeat (3) step();

    // fill the queue: no consumer pops, 1-cycle memory
    tb_rst = 1'b1; tb_ready = 1'b1;
    repeat (18) step();
    #1;
    chk("fill_push_count", 64'(push_log.size()), 64'd8);
    chk("first_push", push_log[0], {32'h0000_0000, 32'hBEEF_0000});
    chk("second_push", push_log[1], {32'h0000_0004, 32'hBEEF_0004});
    chk("eighth_push", push_log[7], {32'h0000_001C, 32'hBEEF_001C});
    chk("full_req_valid", 64'(last_req), 64'h0);
    chk("full_addr", 64'(last_addr), 64'h20);
`ifdef FETCH_PERF_EN
    chk("perf_full10", 64'(perf_stall_cycles), 64'd10);
`endif

    // memory not ready for 5 cycles while consumer drains
    tb_ready = 1'b0; tb_read = 1'b1;
    repeat (5) begin
      step();
      chk("hold_addr", 64'(last_addr), 64'h20);
    end
    chk("hold_req_valid", 64'(last_req), 64'h1);
    tb_ready = 1'b1; tb_read = 1'b0;
    step();
    chk("accept_addr", 64'(last_addr), 64'h20);
    step();
    chk("advance_addr", 64'(last_addr), 64'h24);

    // redirect with two requests in flight
    tb_read = 1'b1; mem_lat = 3;
    for (int i = 0; i < 20 && mq.size() < 2; i++) step();
    chk("two_in_flight", 64'(mq.size()), 64'd2);
    base = push_log.size();
    tb_redir = 1'b1; tb_rpc = 32'h0000_1003;
    step();
    tb_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = last_acc;
    end
    chk("redirect_req_seen", 64'(found), 64'h1);
    chk("redirect_first_addr", 64'(last_addr), 64'h1000);
    chk("stale_pushes", 64'(push_log.size() - base), 64'h0);
    repeat (4) step();
    chk("redirect_first_push", push_log[base], {32'h0000_1000, 32'hBEEF_1000});

    // redirect coinciding with a response and a consumer pop
    mem_lat = 1; tb_read = 1'b0;
    repeat (3) step();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc) found = 1'b1;
      else step();
    end
    chk("rsp_pending_for_redirect", 64'(found), 64'h1);
    tb_redir = 1'b1; tb_rpc = 32'h0000_2000; tb_read = 1'b1;
    step();
    tb_redir = 1'b0;
    chk("redir_cycle_rsp", 64'(last_rsp), 64'h1);
    chk("redir_rsp_dropped", 64'(last_push), 64'h0);
    step();
    chk("redir2_addr", 64'(last_addr), 64'h2000);
    for (int i = 0; i < 12; i++) begin
      tb_read = (i % 3) != 0;
      step();
    end

    // reset in mid-operation
    tb_rst = 1'b0;
    repeat (2) step();
    tb_rst = 1'b1;
    step();
    chk("post_reset_req", 64'(last_req), 64'h1);
    chk("post_reset_addr", 64'(last_addr), 64'h0);
    step();
    chk("post_reset_push", push_log[push_log.size() - 1], {32'h0000_0000, 32'hBEEF_0000});
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
